// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding, load-use /
// branch / multi-cycle stall-flush-bubble control and saturating hazard statistics.
module hazard_ctrl #(
  parameter int REG_COUNT  = 32,
  parameter int REG_BITS   = $clog2(REG_COUNT),
  parameter int CNT_WIDTH  = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [REG_BITS-1:0]  id_rs1,
  input  logic [REG_BITS-1:0]  id_rs2,
  input  logic                 id_use_rs2,
  input  logic [REG_BITS-1:0]  ex_rs1,
  input  logic [REG_BITS-1:0]  ex_rs2,
  input  logic [REG_BITS-1:0]  ex_rd,
  input  logic                 ex_write_en,
  input  logic                 ex_mem_read,
  input  logic                 ex_multicycle,
  input  logic                 branch_taken,
  input  logic [REG_BITS-1:0]  mem_rd,
  input  logic                 mem_write_en,
  input  logic [REG_BITS-1:0]  wb_rd,
  input  logic                 wb_write_en,
  input  logic                 mc_done,
  input  logic                 cnt_clr,
  output logic [1:0]           forward_A,
  output logic [1:0]           forward_B,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 flush_id,
  output logic                 bubble_ex,
  output logic                 bubble_mem,
  output logic                 mc_start,
  output logic                 mc_busy,
  output logic                 hz_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;
  localparam int TO_BITS = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(MC_TIMEOUT - 1);

  logic [0:0]         state, state_nxt;
  logic [TO_BITS-1:0] to_cnt;
  logic               load_use;
  logic               to_hit;
  logic               err_set;

  // EX/MEM wins over MEM/WB; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_BITS-1:0] src,
    input logic [REG_BITS-1:0] m_rd,
    input logic                m_we,
    input logic [REG_BITS-1:0] w_rd,
    input logic                w_we
  );
    if (m_we && (m_rd != '0) && (m_rd == src))      return 2'd1;
    else if (w_we && (w_rd != '0) && (w_rd == src)) return 2'd2;
    else                                            return 2'd0;
  endfunction

  assign forward_A = fwd_sel(ex_rs1, mem_rd, mem_write_en, wb_rd, wb_write_en);
  assign forward_B = fwd_sel(ex_rs2, mem_rd, mem_write_en, wb_rd, wb_write_en);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
  assign to_hit   = (state == MC_WAIT) && !mc_done && (to_cnt == TO_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    flush_id   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    mc_start   = 1'b0;
    mc_busy    = 1'b0;
    err_set    = 1'b0;
    state_nxt  = state;
    // Controls are held low while reset is asserted so an aborted wait is silent.
    if (rstn) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            err_set   = ex_multicycle;
          end else if (ex_multicycle) begin
            mc_start   = 1'b1;
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
            state_nxt  = MC_WAIT;
          end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
          if (mc_done) err_set = 1'b1;
        end
        default: begin
          mc_busy = 1'b1;
          if (mc_done) begin
            state_nxt = RUN;
          end else if (to_hit) begin
            err_set   = 1'b1;
            state_nxt = RUN;
          end else begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= RUN;
      to_cnt <= '0;
      hz_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state  <= state_nxt;
      to_cnt <= (state == MC_WAIT) ? to_cnt + 1'b1 : '0;
      hz_err <= hz_err | err_set;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_id && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // ex_write_en is part of the stage interface but no hazard here depends on it.
  logic unused_ok;
  assign unused_ok = ex_write_en;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, multi-cycle,
// timeout, reset abort, illegal inputs and counter saturation.
module tb_hazard_ctrl;

  localparam int RB = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [RB-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs2, ex_write_en, ex_mem_read, ex_multicycle, branch_taken;
  logic          mem_write_en, wb_write_en, mc_done, cnt_clr;
  logic [1:0]    forward_A, forward_B;
  logic          stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem;
  logic          mc_start, mc_busy, hz_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0]    ctl;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.REG_COUNT(32), .REG_BITS(RB), .CNT_WIDTH(CW), .MC_TIMEOUT(64)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_write_en(ex_write_en),
    .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle), .branch_taken(branch_taken),
    .mem_rd(mem_rd), .mem_write_en(mem_write_en), .wb_rd(wb_rd), .wb_write_en(wb_write_en),
    .mc_done(mc_done), .cnt_clr(cnt_clr),
    .forward_A(forward_A), .forward_B(forward_B),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
    .mc_start(mc_start), .mc_busy(mc_busy), .hz_err(hz_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem, mc_start, mc_busy}
  assign ctl = {stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem, mc_start, mc_busy};

  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
  localparam logic [7:0] C_BRANCH = 8'b0001_1000;
  localparam logic [7:0] C_START  = 8'b1110_0110;
  localparam logic [7:0] C_WAIT   = 8'b1110_0101;
  localparam logic [7:0] C_DONE   = 8'b0000_0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs2 = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_write_en = 0;
    ex_mem_read = 0; ex_multicycle = 0; branch_taken = 0;
    mem_rd = '0; mem_write_en = 0; wb_rd = '0; wb_write_en = 0;
    mc_done = 0; cnt_clr = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_write_en = 1; ex_rd = 5'd7;
    id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1;
  endtask

  initial begin
    idle();
    rstn = 0;
    #3;
    check("reset_ctl", ctl, C_IDLE);
    check("reset_fwd", {forward_A, forward_B}, 4'h0);
    check("reset_err", hz_err, 1'b0);
    check("reset_cnts", {stall_cnt, flush_cnt}, 8'h00);
    #9 rstn = 1;
    tick();

    // Forwarding
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_write_en = 1; wb_rd = 5'd5; wb_write_en = 1;
    #1 check("fwdA_exmem", forward_A, 2'd1);
    mem_write_en = 0;
    #1 check("fwdA_memwb", forward_A, 2'd2);
    ex_rs2 = 5'd0; mem_rd = 5'd0; mem_write_en = 1; wb_write_en = 0;
    #1 check("fwdB_x0", forward_B, 2'd0);
    ex_rs2 = 5'd9; wb_rd = 5'd9; wb_write_en = 1;
    #1 check("fwdB_memwb", forward_B, 2'd2);
    idle();

    // Load-use via rs2
    set_load_use();
    #1 check("lduse_ctl", ctl, C_LDUSE);
    tick();
    check("lduse_cnt", stall_cnt, 4'd1);
    ex_mem_read = 0;
    #1 check("lduse_cleared", ctl, C_IDLE);
    set_load_use();
    id_use_rs2 = 0;
    #1 check("lduse_no_rs2", ctl, C_IDLE);
    tick();
    check("lduse_no_rs2_cnt", stall_cnt, 4'd1);

    // Branch beats load-use
    id_use_rs2 = 1; branch_taken = 1;
    #1 check("branch_ctl", ctl, C_BRANCH);
    tick();
    check("branch_flush_cnt", flush_cnt, 4'd1);
    check("branch_stall_cnt", stall_cnt, 4'd1);
    idle();

    // Multi-cycle with mc_done five cycles after start; branch ignored while waiting
    ex_multicycle = 1;
    #1 check("mc_start_cycle", ctl, C_START);
    tick();
    for (int i = 1; i < 5; i++) begin
      branch_taken = (i == 3);
      #1 check("mc_wait", ctl, C_WAIT);
      tick();
    end
    branch_taken = 0;
    mc_done = 1;
    #1 check("mc_done_cycle", ctl, C_DONE);
    tick();
    mc_done = 0; ex_multicycle = 0;
    #1 check("mc_back_run", ctl, C_IDLE);
    check("mc_stall_cnt", stall_cnt, 4'd6);
    check("mc_flush_cnt", flush_cnt, 4'd1);
    check("mc_no_err", hz_err, 1'b0);

    // Clear, then saturation with clear priority
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    check("clr_cnts", {stall_cnt, flush_cnt}, 8'h00);
    set_load_use();
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cnt", stall_cnt, 4'hf);
    cnt_clr = 1;
    tick();
    check("sat_clr", stall_cnt, 4'd0);
    idle();
    check("pre_timeout_err", hz_err, 1'b0);

    // Timeout: 64 stalled cycles, release on the 65th
    ex_multicycle = 1;
    for (int i = 0; i < 65; i++) begin
      #1 check("to_stall", stall_if, (i < 64) ? 1'b1 : 1'b0);
      check("to_busy", mc_busy, (i > 0) ? 1'b1 : 1'b0);
      tick();
      ex_multicycle = 0;
    end
    check("to_err_set", hz_err, 1'b1);
    check("to_run_ctl", ctl, C_IDLE);
    tick();
    check("to_err_sticky", hz_err, 1'b1);

    // Reset mid-wait aborts silently
    ex_multicycle = 1;
    tick();
    ex_multicycle = 0;
    tick();
    tick();
    check("abort_busy", mc_busy, 1'b1);
    #2 rstn = 0;
    #1 check("abort_ctl", ctl, C_IDLE);
    check("abort_err", hz_err, 1'b0);
    check("abort_cnt", stall_cnt, 4'd0);
    #1 rstn = 1;
    tick();
    check("abort_no_restart", ctl, C_IDLE);

    // Illegal: mc_done in RUN
    mc_done = 1;
    #1 check("ill_done_ctl", ctl, C_IDLE);
    tick();
    mc_done = 0;
    check("ill_done_err", hz_err, 1'b1);

    // Illegal: branch with multi-cycle; branch still wins
    rstn = 0;
    #2 rstn = 1;
    tick();
    branch_taken = 1; ex_multicycle = 1;
    #1 check("ill_bm_ctl", ctl, C_BRANCH);
    tick();
    idle();
    #1 check("ill_bm_err", hz_err, 1'b1);
    check("ill_bm_run", mc_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Drives the forward_A/forward_B operand-mux selects into the execute stage.
- Generates stall, flush and bubble controls for the IF/ID, ID/EX and EX/MEM registers, covering load-use hazards, taken branches and multi-cycle EX operations.
- Sequences the start/done handshake of the multi-cycle unit and keeps saturating hazard statistics counters.

Parameters:
REG_COUNT, 32, number of architectural registers
REG_BITS, $clog2(REG_COUNT), register index width
CNT_WIDTH, 16, width of statistics counters
MC_TIMEOUT, 64, max cycles to wait for mc_done before abort

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  REG_BITS  source regs of instruction in decode
id_use_rs2  in  1  decode instruction actually reads rs2
ex_rs1, ex_rs2, ex_rd  in  REG_BITS  regs of instruction in execute
ex_write_en  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
ex_multicycle  in  1  EX instruction needs the multi-cycle unit
branch_taken  in  1  EX branch/jump resolved taken this cycle
mem_rd  in  REG_BITS  rd in EX/MEM register
mem_write_en  in  1  EX/MEM writes rd
wb_rd  in  REG_BITS  rd in MEM/WB register
wb_write_en  in  1  MEM/WB writes rd
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
cnt_clr  in  1  synchronous clear of statistics counters
forward_A, forward_B  out  2  operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
flush_id  out  1  load NOP into IF/ID
bubble_ex  out  1  load NOP into ID/EX
bubble_mem  out  1  load NOP into EX/MEM
mc_start  out  1  start pulse to multi-cycle unit
mc_busy  out  1  FSM in MC_WAIT
hz_err  out  1  sticky error flag
stall_cnt, flush_cnt  out  CNT_WIDTH  statistics counters

Behaviour:
- The interface has one clock, clk. Reset rstn is asynchronous and active-low.
- On reset:
  - FSM goes to RUN and the timeout counter clears.
  - hz_err=0, stall_cnt=0, flush_cnt=0.
  - All combinational outputs evaluate to 0, because no hazard is active in RUN with idle inputs.
- Forwarding is combinational and has zero latency. forward_A uses ex_rs1 and forward_B uses ex_rs2, evaluated independently:
  - Select 1 if mem_write_en, mem_rd!=0 and mem_rd==src.
  - Otherwise select 2 if wb_write_en, wb_rd!=0 and wb_rd==src.
  - Otherwise select 0.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded. Forwarding stays active during stalls.
- Load-use hazard: ex_mem_read, ex_rd!=0 and (ex_rd==id_rs1, or id_use_rs2 and ex_rd==id_rs2).
- FSM states are RUN and MC_WAIT. Outputs are Mealy.
- RUN, priority branch_taken > ex_multicycle > load-use:
  - branch_taken: flush_id=1, bubble_ex=1, no stall. flush_cnt increments.
  - ex_multicycle: mc_start=1 for exactly this cycle. stall_if=stall_id=stall_ex=1, bubble_mem=1. Next state MC_WAIT, timeout counter cleared.
  - load-use: stall_if=stall_id=1, bubble_ex=1 for one cycle. The condition clears naturally as the load advances.
  - Every cycle with stall_if=1 increments stall_cnt.
- MC_WAIT:
  - mc_busy=1 and the timeout counter increments.
  - If mc_done=0: stall_if=stall_id=stall_ex=1, bubble_mem=1.
  - If mc_done=1: all stalls and bubbles deassert in the same cycle, so EX/MEM captures the result. Next state RUN.
  - If the counter reaches MC_TIMEOUT-1 without mc_done: hz_err<=1, stalls release this cycle, next state RUN.
  - branch_taken and load-use are ignored in MC_WAIT.
- mc_start never asserts in MC_WAIT. On the RUN cycle after release, a new EX instruction may start immediately.
- Illegal input combinations set hz_err<=1 with priority unchanged:
  - branch_taken together with ex_multicycle in RUN.
  - mc_done in RUN.
- Counters saturate at all-ones and never wrap. cnt_clr has priority over increment.
- hz_err clears only on reset.
- Reset asserted mid-MC_WAIT aborts to RUN immediately; no mc_start is reissued.

Test Plan:
- Forwarding:
  - ex_rs1=5, mem_rd=5, mem_write_en=1, wb_rd=5, wb_write_en=1 -> forward_A=1.
  - Then mem_write_en=0 -> forward_A=2.
  - ex_rs2=0, mem_rd=0, mem_write_en=1 -> forward_B=0.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_use_rs2=1 -> stall_if=stall_id=bubble_ex=1 for one cycle, stall_cnt 0->1.
  - With id_use_rs2=0 -> no stall.
- Taken branch with a simultaneous load-use condition -> flush_id=bubble_ex=1, stall_if=0, flush_cnt=1.
- Multi-cycle op with mc_done pulsed 5 cycles after mc_start:
  - mc_start high for exactly 1 cycle.
  - Stalls high for 5 cycles and low in the mc_done cycle.
  - mc_busy high for 5 cycles, then RUN.
- Timeout: ex_multicycle=1, never mc_done, MC_TIMEOUT=64 -> stalls release after 65 total cycles and hz_err=1 stays set.
  - rstn low mid-wait -> all outputs 0 asynchronously.
- Saturation: CNT_WIDTH=4, 20 load-use stalls -> stall_cnt=15. Then cnt_clr=1 -> 0 next cycle.
